// File: rtl/jtag_host_sequencer.sv
// jtag_host_sequencer: turns IR-load/DR-shift commands into TCK/TMS/TDI waveforms and captures TDO
module jtag_host_sequencer #(
   parameter int DR_MAX  = 32,
   parameter int IR_W    = 4,
   parameter int TCK_DIV = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_TYPE,
   input  logic [5:0]        CMD_LEN,
   input  logic [DR_MAX-1:0] CMD_DATA,
   output logic              RSP_VALID,
   output logic [DR_MAX-1:0] RSP_DATA,
   output logic              TCK,
   output logic              TMS,
   output logic              TDI,
   input  logic              TDO,
   output logic              TRSTN
);
   localparam int SW = $clog2((DR_MAX > 6 ? DR_MAX : 6) + 1);
   localparam int HW = TCK_DIV > 1 ? $clog2(TCK_DIV) : 1;
   localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_PRE = 3'd2, S_SHIFT = 3'd3, S_POST = 3'd4;
   logic [2:0] state_q, state_d;
   logic [SW-1:0] step_q, step_d, len_q, len_d, last_step;
   logic [HW-1:0] hc_q, hc_d;
   logic tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, trstn_q, trstn_d;
   logic typ_q, typ_d, rsp_valid_q, rsp_valid_d;
   logic [DR_MAX-1:0] data_q, data_d, rsp_q, rsp_d;
   logic run, half_end, rise, fall;

   always_comb begin
      run = state_q != S_IDLE && trstn_q;
      half_end = run && hc_q == HW'(TCK_DIV - 1);
      rise = half_end && !tck_q;
      fall = half_end && tck_q;
      last_step = state_q == S_INIT ? SW'(5) :
                  state_q == S_PRE ? (typ_q ? SW'(2) : SW'(3)) :
                  state_q == S_SHIFT ? len_q - SW'(1) : SW'(1);
      state_d = state_q;
      step_d = step_q;
      typ_d = typ_q;
      len_d = len_q;
      data_d = data_q;
      rsp_d = rsp_q;
      rsp_valid_d = 1'b0;
      trstn_d = 1'b1;
      hc_d = run ? (half_end ? '0 : hc_q + HW'(1)) : hc_q;
      tck_d = half_end ? !tck_q : tck_q;
      if (rise && state_q == S_SHIFT)
         rsp_d = rsp_q | (DR_MAX'(TDO) << step_q);
      // a step ends on the falling TCK transition; the next step's TMS/TDI launch on that same edge
      if (fall && step_q != last_step) begin
         step_d = step_q + SW'(1);
         if (state_q == S_SHIFT)
            data_d = data_q >> 1;
      end else if (fall) begin
         step_d = '0;
         state_d = state_q == S_PRE ? S_SHIFT : state_q == S_SHIFT ? S_POST : S_IDLE;
         rsp_valid_d = state_q == S_POST;
      end
      if (state_q == S_IDLE && CMD_VALID) begin
         state_d = S_PRE;
         step_d = '0;
         typ_d = CMD_TYPE;
         len_d = !CMD_TYPE ? SW'(IR_W) :
                 CMD_LEN == 6'd0 ? SW'(1) :
                 int'(CMD_LEN) > DR_MAX ? SW'(DR_MAX) : SW'(CMD_LEN);
         data_d = CMD_DATA;
         rsp_d = '0;
      end
      // TMS/TDI are a pure function of the step about to run, so they only move when the step does
      tms_d = state_d == S_INIT ? step_d != SW'(5) :
              state_d == S_PRE ? (typ_d ? step_d == SW'(0) : step_d < SW'(2)) :
              state_d == S_SHIFT ? step_d == len_d - SW'(1) :
              state_d == S_POST ? step_d == SW'(0) : 1'b0;
      tdi_d = state_d == S_SHIFT && data_d[0];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_INIT;
         step_q <= '0;
         len_q <= '0;
         hc_q <= '0;
         tck_q <= 1'b0;
         tms_q <= 1'b1;
         tdi_q <= 1'b0;
         trstn_q <= 1'b0;
         typ_q <= 1'b0;
         data_q <= '0;
         rsp_q <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q <= step_d;
         len_q <= len_d;
         hc_q <= hc_d;
         tck_q <= tck_d;
         tms_q <= tms_d;
         tdi_q <= tdi_d;
         trstn_q <= trstn_d;
         typ_q <= typ_d;
         data_q <= data_d;
         rsp_q <= rsp_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign CMD_READY = state_q == S_IDLE;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_DATA = rsp_q;
   assign TCK = tck_q;
   assign TMS = tms_q;
   assign TDI = tdi_q;
   assign TRSTN = trstn_q;
endmodule

// File: tb/tb_jtag_host_sequencer.sv
// tb_jtag_host_sequencer: directed vectors against a behavioural TAP (bypass DR, 4-bit IR)
module tb_jtag_host_sequencer;
   localparam int DR_MAX = 32, IR_W = 4, TCK_DIV = 2;
   localparam logic [3:0] TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PSDR = 6,
                          EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12,
                          PSIR = 13, EX2IR = 14, UPIR = 15;
   typedef struct {
      logic        typ;
      logic [5:0]  len;
      logic [31:0] data;
      logic        tie;
      logic [31:0] rsp;
      int          rises;
      int          nsh;
      logic [63:0] tms;
      logic [63:0] tdi;
   } vec_t;

   logic CLK = 1'b0, RST, CMD_VALID, CMD_READY, CMD_TYPE, RSP_VALID, TCK, TMS, TDI, TDO, TRSTN;
   logic [5:0] CMD_LEN;
   logic [31:0] CMD_DATA, RSP_DATA;
   logic tie_hi = 1'b0, tdo_m = 1'b0, byp = 1'b0;
   logic [3:0] tap = TLR, ir_sr = 4'b0;
   logic tms_arr [0:8191];
   logic tdi_arr [0:8191];
   int n_rise = 0, n_sh = 0, base_r, base_s, last_wt, total = 0, bad = 0;
   vec_t v [8];

   jtag_host_sequencer #(.DR_MAX(DR_MAX), .IR_W(IR_W), .TCK_DIV(TCK_DIV)) dut (
      .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_TYPE(CMD_TYPE),
      .CMD_LEN(CMD_LEN), .CMD_DATA(CMD_DATA), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
      .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TRSTN(TRSTN)
   );

   always #5 CLK = !CLK;
   assign TDO = tie_hi ? 1'b1 : tdo_m;

   function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
      case (s)
         TLR:   return m ? TLR : RTI;
         RTI:   return m ? SELDR : RTI;
         SELDR: return m ? SELIR : CAPDR;
         CAPDR: return m ? EX1DR : SHDR;
         SHDR:  return m ? EX1DR : SHDR;
         EX1DR: return m ? UPDR : PSDR;
         PSDR:  return m ? EX2DR : PSDR;
         EX2DR: return m ? UPDR : SHDR;
         SELIR: return m ? TLR : CAPIR;
         CAPIR: return m ? EX1IR : SHIR;
         SHIR:  return m ? EX1IR : SHIR;
         EX1IR: return m ? UPIR : PSIR;
         PSIR:  return m ? EX2IR : PSIR;
         EX2IR: return m ? UPIR : SHIR;
         default: return m ? SELDR : RTI;
      endcase
   endfunction

   always @(posedge TCK or negedge TRSTN) begin
      if (!TRSTN) tap <= TLR;
      else begin
         if (tap == CAPDR) byp <= 1'b0;
         if (tap == SHDR) byp <= TDI;
         if (tap == CAPIR) ir_sr <= 4'b0001;
         if (tap == SHIR) ir_sr <= {TDI, ir_sr[3:1]};
         if (tap == SHDR || tap == SHIR) n_sh <= n_sh + 1;
         tap <= tap_next(tap, TMS);
      end
   end
   always @(negedge TCK) tdo_m <= tap == SHDR ? byp : tap == SHIR ? ir_sr[0] : 1'b0;
   always @(posedge TCK) begin
      tms_arr[n_rise] <= TMS;
      tdi_arr[n_rise] <= TDI;
      n_rise <= n_rise + 1;
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   function automatic logic [63:0] grab(input logic dsel);
      logic [63:0] r = '0;
      for (int i = 0; i < 64; i++)
         if (i < n_rise - base_r) r[i] = dsel ? tdi_arr[base_r + i] : tms_arr[base_r + i];
      return r;
   endfunction

   task automatic init_check();
      int k;
      chk("init_trstn_low", TRSTN, 0);
      RST = 1'b0;
      base_r = n_rise;
      @(posedge CLK); #1;
      chk("init_trstn_first_edge", TRSTN, 1);
      k = 1;
      while (!CMD_READY && k < 500) begin @(posedge CLK); #1; k++; end
      chk("init_ready_lat", k, 25);
      chk("init_rises", n_rise - base_r, 6);
      chk("init_tms_seq", grab(1'b0), 64'h1F);
      chk("init_tap_rti", tap, RTI);
   endtask

   task automatic run_cmd(input logic typ, input logic [5:0] len, input logic [31:0] data,
                          input logic hold, output int wt, output int lat);
      CMD_TYPE = typ; CMD_LEN = len; CMD_DATA = data; CMD_VALID = 1'b1;
      wt = 0;
      while (!CMD_READY && wt < 500) begin @(posedge CLK); #1; wt++; end
      base_r = n_rise;
      base_s = n_sh;
      @(posedge CLK); #1;
      if (!hold) CMD_VALID = 1'b0;
      chk("accept_ready_low", CMD_READY, 0);
      chk("accept_rsp_cleared", RSP_DATA, 0);
      lat = 0;
      while (!RSP_VALID && lat < 2000) begin @(posedge CLK); #1; lat++; end
   endtask

   task automatic apply(input int id, input vec_t t, input logic hold);
      int wt, lat;
      string p;
      p = $sformatf("v%0d", id);
      tie_hi = t.tie;
      run_cmd(t.typ, t.len, t.data, hold, wt, lat);
      last_wt = wt;
      chk({p, "_lat"}, lat, t.rises * 2 * TCK_DIV);
      chk({p, "_rsp"}, RSP_DATA, t.rsp);
      chk({p, "_rises"}, n_rise - base_r, t.rises);
      chk({p, "_tms"}, grab(1'b0), t.tms);
      chk({p, "_tdi"}, grab(1'b1), t.tdi);
      chk({p, "_shifts"}, n_sh - base_s, t.nsh);
      chk({p, "_tap_rti"}, tap, RTI);
      chk({p, "_ready_at_done"}, CMD_READY, 1);
      if (!hold) begin
         @(posedge CLK); #1;
         chk({p, "_rsp_pulse"}, RSP_VALID, 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wt, lat;
      v[0] = '{1'b0, 6'd0,  32'h0000000D, 1'b0, 32'h00000001, 10, 4,  64'h183, 64'hD0};
      v[1] = '{1'b1, 6'd5,  32'h00000019, 1'b1, 32'h0000001F, 10, 5,  64'h181, 64'hC8};
      v[2] = '{1'b1, 6'd5,  32'h00000019, 1'b0, 32'h00000012, 10, 5,  64'h181, 64'hC8};
      v[3] = '{1'b1, 6'd0,  32'hFFFFFFFF, 1'b0, 32'h00000000, 6,  1,  64'h19,  64'h8};
      v[4] = '{1'b1, 6'd40, 32'hA5C30F69, 1'b0, 32'h4B861ED2, 37, 32, 64'hC_0000_0001, 64'h5_2E18_7B48};
      v[5] = '{1'b1, 6'd32, 32'h80000001, 1'b1, 32'hFFFFFFFF, 37, 32, 64'hC_0000_0001, 64'h4_0000_0008};
      v[6] = '{1'b0, 6'd9,  32'hFFFFFFF5, 1'b0, 32'h00000001, 10, 4,  64'h183, 64'h50};
      v[7] = '{1'b1, 6'd3,  32'h00000006, 1'b0, 32'h00000004, 8,  3,  64'h61,  64'h30};
      RST = 1'b1; CMD_VALID = 1'b0; CMD_TYPE = 1'b0; CMD_LEN = 6'd0; CMD_DATA = 32'h0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_tck", TCK, 0);
      chk("rst_tms", TMS, 1);
      chk("rst_tdi", TDI, 0);
      chk("rst_trstn", TRSTN, 0);
      chk("rst_ready", CMD_READY, 0);
      chk("rst_rsp_valid", RSP_VALID, 0);
      chk("rst_rsp_data", RSP_DATA, 0);
      init_check();
      for (int i = 0; i < 8; i++) apply(i, v[i], 1'b0);
      // abort in the middle of shift step 2 while TCK is high
      tie_hi = 1'b0;
      CMD_TYPE = 1'b1; CMD_LEN = 6'd8; CMD_DATA = 32'hA5; CMD_VALID = 1'b1;
      wt = 0;
      while (!CMD_READY && wt < 500) begin @(posedge CLK); #1; wt++; end
      base_s = n_sh;
      @(posedge CLK); #1;
      CMD_VALID = 1'b0;
      repeat (23) @(posedge CLK);
      #1;
      chk("mid_tck_high", TCK, 1);
      chk("mid_shifts", n_sh - base_s, 3);
      RST = 1'b1;
      #1;
      chk("abort_tck", TCK, 0);
      chk("abort_tms", TMS, 1);
      chk("abort_trstn", TRSTN, 0);
      chk("abort_tdi", TDI, 0);
      chk("abort_ready", CMD_READY, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         chk("abort_no_rsp", RSP_VALID, 0);
      end
      init_check();
      apply(8, v[2], 1'b0);
      // CMD_VALID held high across two commands of different types
      apply(9, v[0], 1'b1);
      apply(10, v[7], 1'b1);
      chk("b2b_accept_wait", last_wt, 0);
      CMD_VALID = 1'b0;
      @(posedge CLK); #1;
      chk("b2b_rsp_pulse", RSP_VALID, 0);
      chk("b2b_idle", CMD_READY, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
